// File: rtl/spi_pkg.sv
// Shared types for the SPI burst sequencer: FSM state encoding and byte width.
package spi_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LAUNCH,
      XFER,
      WAIT_IDLE,
      DRAIN
   } seq_state_t;

endpackage

// File: rtl/spi_seq_buffer.sv
// Burst byte buffer: DEPTH x 8 register array, one synchronous write, one async read.
// Deliberately not reset; contents are always rewritten before they are read.
module spi_seq_buffer
   import spi_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [SPI_BYTE_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [SPI_BYTE_W-1:0] rd_data
);

   logic [SPI_BYTE_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/spi_burst_sequencer.sv
// Sequences an N-byte burst through the byte-level SPI controller under one CS assertion.
// Optional feature macro SPI_SEQ_RX_SKIP_EN: discard the first cmd_skip received bytes.
module spi_burst_sequencer
   import spi_pkg::*;
#(
   parameter  int MAX_LEN = 16,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_W-1:0]      cmd_len,
`ifdef SPI_SEQ_RX_SKIP_EN
   input  logic [LEN_W-1:0]      cmd_skip,
`endif
   output logic                  cmd_err,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_last,
   output logic                  seq_busy,
   output logic                  ctrl_start,
   output logic [SPI_BYTE_W-1:0] ctrl_data_to_send,
   output logic                  ctrl_hold_cs,
   input  logic                  ctrl_busy,
   input  logic                  ctrl_done,
   input  logic [SPI_BYTE_W-1:0] ctrl_data_received,
   input  logic                  ctrl_sclk
);

   localparam int ADDR_W = $clog2(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   seq_state_t state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      wr_idx_q, wr_idx_d;
   logic [LEN_W-1:0]      rx_idx_q, rx_idx_d;
   logic [LEN_W-1:0]      rd_idx_q, rd_idx_d;
   logic [LEN_W-1:0]      byte_idx_q, byte_idx_d;
   logic [2:0]            edge_cnt_q, edge_cnt_d;
   logic                  sclk_q, sclk_d;
   logic                  start_q, start_d;
   logic [SPI_BYTE_W-1:0] data_q, data_d;
   logic                  hold_q, hold_d;
   logic                  err_q, err_d;

   logic                  buf_we;
   logic [ADDR_W-1:0]     buf_waddr;
   logic [SPI_BYTE_W-1:0] buf_wdata;
   logic [ADDR_W-1:0]     buf_raddr;
   logic [SPI_BYTE_W-1:0] buf_rdata;

   logic [LEN_W-1:0]      skip_len;
   logic                  cmd_ok;
   logic                  sclk_rise;
   logic [LEN_W-1:0]      next_idx;
   logic [LEN_W-1:0]      rx_wr_idx;
   logic [LEN_W-1:0]      out_len;
   logic                  drain_last;

`ifdef SPI_SEQ_RX_SKIP_EN
   logic [LEN_W-1:0] skip_q, skip_d;
   assign skip_len = skip_q;
   assign cmd_ok   = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN)) && (cmd_skip < cmd_len);
`else
   assign skip_len = '0;
   assign cmd_ok   = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));
`endif

   assign sclk_rise  = ctrl_sclk & ~sclk_q;
   assign next_idx   = byte_idx_q + ONE;
   assign rx_wr_idx  = rx_idx_q - skip_len;
   assign out_len    = len_q - skip_len;
   assign drain_last = (rd_idx_q == out_len - ONE);

   spi_seq_buffer #(
      .DEPTH  (MAX_LEN),
      .ADDR_W (ADDR_W)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (buf_waddr),
      .wr_data (buf_wdata),
      .rd_addr (buf_raddr),
      .rd_data (buf_rdata)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_idx_d   = wr_idx_q;
      rx_idx_d   = rx_idx_q;
      rd_idx_d   = rd_idx_q;
      byte_idx_d = byte_idx_q;
      edge_cnt_d = edge_cnt_q;
      sclk_d     = ctrl_sclk;
      start_d    = 1'b0;
      data_d     = data_q;
      hold_d     = hold_q;
      err_d      = 1'b0;
      buf_we     = 1'b0;
      buf_waddr  = wr_idx_q[ADDR_W-1:0];
      buf_wdata  = tx_data;
      buf_raddr  = '0;
`ifdef SPI_SEQ_RX_SKIP_EN
      skip_d     = skip_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_ok) begin
                  len_d    = cmd_len;
                  wr_idx_d = '0;
                  state_d  = LOAD;
`ifdef SPI_SEQ_RX_SKIP_EN
                  skip_d   = cmd_skip;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (tx_valid) begin
               buf_we   = 1'b1;
               wr_idx_d = wr_idx_q + ONE;
               if (wr_idx_q == len_q - ONE) begin
                  state_d = LAUNCH;
               end
            end
         end
         LAUNCH: begin
            if (!ctrl_busy) begin
               data_d     = buf_rdata;
               hold_d     = (len_q > ONE);
               start_d    = 1'b1;
               byte_idx_d = '0;
               edge_cnt_d = '0;
               rx_idx_d   = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            // The next TX byte is fetched on the last SCLK edge of the current one,
            // before its RX byte lands, so the shared buffer slot is never clobbered early.
            buf_raddr = next_idx[ADDR_W-1:0];
            if (sclk_rise) begin
               edge_cnt_d = edge_cnt_q + 3'd1;
               if ((edge_cnt_q == 3'd7) && (next_idx < len_q)) begin
                  data_d     = buf_rdata;
                  hold_d     = (next_idx + ONE < len_q);
                  byte_idx_d = next_idx;
               end
            end
            if (ctrl_done) begin
               rx_idx_d  = rx_idx_q + ONE;
               buf_we    = (rx_idx_q >= skip_len);
               buf_waddr = rx_wr_idx[ADDR_W-1:0];
               buf_wdata = ctrl_data_received;
               if (rx_idx_q == len_q - ONE) begin
                  state_d = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            hold_d = 1'b0;
            if (!ctrl_busy) begin
               rd_idx_d = '0;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            buf_raddr = rd_idx_q[ADDR_W-1:0];
            if (rx_ready) begin
               rd_idx_d = rd_idx_q + ONE;
               if (drain_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wr_idx_q   <= '0;
         rx_idx_q   <= '0;
         rd_idx_q   <= '0;
         byte_idx_q <= '0;
         edge_cnt_q <= '0;
         sclk_q     <= 1'b0;
         start_q    <= 1'b0;
         data_q     <= '0;
         hold_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef SPI_SEQ_RX_SKIP_EN
         skip_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_idx_q   <= wr_idx_d;
         rx_idx_q   <= rx_idx_d;
         rd_idx_q   <= rd_idx_d;
         byte_idx_q <= byte_idx_d;
         edge_cnt_q <= edge_cnt_d;
         sclk_q     <= sclk_d;
         start_q    <= start_d;
         data_q     <= data_d;
         hold_q     <= hold_d;
         err_q      <= err_d;
`ifdef SPI_SEQ_RX_SKIP_EN
         skip_q     <= skip_d;
`endif
      end
   end

   assign cmd_ready         = (state_q == IDLE);
   assign seq_busy          = (state_q != IDLE);
   assign tx_ready          = (state_q == LOAD);
   assign rx_valid          = (state_q == DRAIN);
   assign rx_data           = rx_valid ? buf_rdata : '0;
   assign rx_last           = rx_valid & drain_last;
   assign cmd_err           = err_q;
   assign ctrl_start        = start_q;
   assign ctrl_data_to_send = data_q;
   assign ctrl_hold_cs      = hold_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Randomized bench: a behavioural SPI controller/slave model plus an expected-RX queue.
// Build with +define+SPI_SEQ_RX_SKIP_EN to also exercise the RX skip feature.
`timescale 1ns/1ps
module tb_spi_burst_sequencer;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
`ifdef SPI_SEQ_RX_SKIP_EN
   logic [LEN_W-1:0] cmd_skip;
`endif
   logic             cmd_err;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       tx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       rx_data;
   logic             rx_last;
   logic             seq_busy;
   logic             ctrl_start;
   logic [7:0]       ctrl_data_to_send;
   logic             ctrl_hold_cs;
   logic             ctrl_busy;
   logic             ctrl_done;
   logic [7:0]       ctrl_data_received;
   logic             ctrl_sclk;

   spi_burst_sequencer #(.MAX_LEN(MAX_LEN)) dut (
      .clk                (clk),
      .rst                (rst),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_len            (cmd_len),
`ifdef SPI_SEQ_RX_SKIP_EN
      .cmd_skip           (cmd_skip),
`endif
      .cmd_err            (cmd_err),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .tx_data            (tx_data),
      .rx_valid           (rx_valid),
      .rx_ready           (rx_ready),
      .rx_data            (rx_data),
      .rx_last            (rx_last),
      .seq_busy           (seq_busy),
      .ctrl_start         (ctrl_start),
      .ctrl_data_to_send  (ctrl_data_to_send),
      .ctrl_hold_cs       (ctrl_hold_cs),
      .ctrl_busy          (ctrl_busy),
      .ctrl_done          (ctrl_done),
      .ctrl_data_received (ctrl_data_received),
      .ctrl_sclk          (ctrl_sclk)
   );

   always #5 clk = ~clk;

   logic [7:0] tx_bytes  [MAX_LEN];
   logic [7:0] slv_bytes [MAX_LEN];
   logic [7:0] exp_rx [$];
   bit         exp_last [$];
   int         cur_len;
   int         checks = 0;
   int         errors = 0;
   int         start_count = 0;
   int         ctrl_byte_idx = -1;
   int         ctrl_edges = 0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] last_sent = 8'h00;
   bit         rdy_toggle = 1'b0;
   bit         tx_gaps = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Controller/slave model: a start pulse begins a burst; each byte is shifted MSB first
   // over 8 SCLK pulses, and CS stays low only while the hold flag seen at byte start is set.
   task automatic ctrl_wait(input int n, output bit ab);
      ab = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (rst) begin
            ab = 1'b1;
            return;
         end
      end
   endtask

   task automatic ctrl_idle();
      ctrl_busy = 1'b0;
      ctrl_sclk = 1'b0;
      ctrl_done = 1'b0;
   endtask

   task automatic run_ctrl_burst(input logic [7:0] d0, input logic h0);
      logic [7:0] d;
      logic [7:0] shifted;
      logic       h;
      bit         ab;
      int         k;
      d = d0;
      h = h0;
      k = 0;
      ctrl_wait(1, ab);
      if (ab) begin ctrl_idle(); return; end
      ctrl_busy = 1'b1;
      forever begin
         ctrl_byte_idx = k;
         check_output("hold_cs_at_byte_start", 32'(h), 32'(k < cur_len - 1));
         shifted = '0;
         for (int b = 7; b >= 0; b--) begin
            ctrl_sclk = 1'b0;
            ctrl_wait(2, ab);
            if (ab) begin ctrl_idle(); return; end
            ctrl_sclk = 1'b1;
            ctrl_edges++;
            shifted = {shifted[6:0], d[b]};
            ctrl_wait(2, ab);
            if (ab) begin ctrl_idle(); return; end
         end
         ctrl_sclk = 1'b0;
         ctrl_wait(1, ab);
         if (ab) begin ctrl_idle(); return; end
         last_sent = shifted;
         if (k < MAX_LEN) begin
            check_output("tx_byte_sent", 32'(shifted), 32'(tx_bytes[k]));
            ctrl_data_received = slv_bytes[k];
         end
         ctrl_done = 1'b1;
         ctrl_wait(1, ab);
         ctrl_done = 1'b0;
         if (ab) begin ctrl_idle(); return; end
         if (!h || k >= MAX_LEN - 1) begin
            ctrl_busy = 1'b0;
            return;
         end
         k++;
         d = ctrl_data_to_send;
         h = ctrl_hold_cs;
      end
   endtask

   initial begin
      ctrl_idle();
      ctrl_data_received = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && ctrl_start) begin
            run_ctrl_burst(ctrl_data_to_send, ctrl_hold_cs);
         end
      end
   end

   initial begin
      rx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rx_ready = rdy_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: every accepted RX byte must be the next expected one, in order.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      bit         exp_l;
      if (!rst) begin
         if (ctrl_start) start_count++;
         check_output("busy_is_not_ready", 32'(seq_busy), 32'(!cmd_ready));
         if (rx_valid && rx_ready) begin
            if (exp_rx.size() == 0) begin
               check_output("rx_unexpected_byte", 32'(rx_valid), 32'(0));
            end else begin
               exp_b = exp_rx.pop_front();
               exp_l = exp_last.pop_front();
               check_output("rx_data", 32'(rx_data), 32'(exp_b));
               check_output("rx_last", 32'(rx_last), 32'(exp_l));
               last_rx = rx_data;
            end
         end
      end
   end

   task automatic check_reset_outputs();
      check_output("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      check_output("rst_seq_busy", 32'(seq_busy), 32'(0));
      check_output("rst_tx_ready", 32'(tx_ready), 32'(0));
      check_output("rst_rx_valid", 32'(rx_valid), 32'(0));
      check_output("rst_rx_last", 32'(rx_last), 32'(0));
      check_output("rst_cmd_err", 32'(cmd_err), 32'(0));
      check_output("rst_ctrl_start", 32'(ctrl_start), 32'(0));
      check_output("rst_ctrl_hold_cs", 32'(ctrl_hold_cs), 32'(0));
      check_output("rst_ctrl_data", 32'(ctrl_data_to_send), 32'(0));
   endtask

   task automatic apply_stimulus(input int len, input int skip, input int abort_at);
      int starts0;
      int guard;
      cur_len       = len;
      starts0       = start_count;
      ctrl_edges    = 0;
      ctrl_byte_idx = -1;
      exp_rx.delete();
      exp_last.delete();
      if (abort_at < 0) begin
         for (int i = skip; i < len; i++) begin
            exp_rx.push_back(slv_bytes[i]);
            exp_last.push_back(i == len - 1);
         end
      end
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
`ifdef SPI_SEQ_RX_SKIP_EN
      cmd_skip  = LEN_W'(skip);
`endif
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (tx_gaps) begin
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
         end
         guard = 0;
         while (!tx_ready && guard < 50) begin tick(); guard++; end
         check_output("tx_ready_in_load", 32'(tx_ready), 32'(1));
         tx_valid = 1'b1;
         tx_data  = tx_bytes[i];
         tick();
      end
      tx_valid = 1'b0;
      check_output("tx_ready_after_load", 32'(tx_ready), 32'(0));
      if (abort_at >= 0) begin
         guard = 0;
         while (ctrl_byte_idx != abort_at && guard < 2000) begin tick(); guard++; end
         check_output("reached_abort_byte", 32'(ctrl_byte_idx), 32'(abort_at));
         repeat (5) tick();
         rst = 1'b1;
         #1;
         check_reset_outputs();
         repeat (3) tick();
         rst = 1'b0;
         tick();
         check_output("abort_start_pulses", 32'(start_count - starts0), 32'(1));
      end else begin
         guard = 0;
         while ((exp_rx.size() != 0 || seq_busy) && guard < 5000) begin tick(); guard++; end
         check_output("burst_complete", 32'(exp_rx.size() == 0 && !seq_busy), 32'(1));
         check_output("cmd_ready_after_drain", 32'(cmd_ready), 32'(1));
         check_output("start_pulses", 32'(start_count - starts0), 32'(1));
         check_output("sclk_edges", 32'(ctrl_edges), 32'(8 * len));
      end
   endtask

   task automatic apply_bad_cmd(input int len, input int skip);
      int starts0;
      starts0   = start_count;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
`ifdef SPI_SEQ_RX_SKIP_EN
      cmd_skip  = LEN_W'(skip);
`else
      if (skip != 0) $display("[TB] skip ignored without RX skip feature");
`endif
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      check_output("cmd_err_pulse", 32'(cmd_err), 32'(1));
      check_output("bad_cmd_stays_idle", 32'(seq_busy), 32'(0));
      tick();
      check_output("cmd_err_one_cycle", 32'(cmd_err), 32'(0));
      check_output("bad_cmd_ready", 32'(cmd_ready), 32'(1));
      repeat (5) tick();
      check_output("bad_cmd_no_start", 32'(start_count - starts0), 32'(0));
   endtask

   task automatic fill_random(input int len);
      for (int i = 0; i < len; i++) begin
         tx_bytes[i]  = 8'($urandom);
         slv_bytes[i] = 8'($urandom);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
`ifdef SPI_SEQ_RX_SKIP_EN
      cmd_skip  = '0;
`endif
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      repeat (3) tick();
      check_reset_outputs();
      rst = 1'b0;
      tick();

      $display("[TB] single byte burst");
      tx_bytes[0]  = 8'hA5;
      slv_bytes[0] = 8'h3C;
      apply_stimulus(1, 0, -1);
      check_output("t1_sent_literal", 32'(last_sent), 32'h A5);
      check_output("t1_rx_literal", 32'(last_rx), 32'h 3C);

      $display("[TB] three byte burst");
      tx_bytes[0:2]  = '{8'h0B, 8'h00, 8'h00};
      slv_bytes[0:2] = '{8'hFF, 8'h12, 8'h34};
      apply_stimulus(3, 0, -1);
      check_output("t2_rx_literal", 32'(last_rx), 32'h 34);

      $display("[TB] full length burst with gaps and backpressure");
      tx_gaps    = 1'b1;
      rdy_toggle = 1'b1;
      fill_random(16);
      apply_stimulus(16, 0, -1);

      $display("[TB] illegal lengths");
      apply_bad_cmd(0, 0);
      apply_bad_cmd(17, 0);

      $display("[TB] reset during byte 2 of 4");
      fill_random(4);
      apply_stimulus(4, 0, 2);
      fill_random(2);
      apply_stimulus(2, 0, -1);

      $display("[TB] random bursts");
      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(1, MAX_LEN);
         tx_gaps    = 1'($urandom_range(0, 1));
         rdy_toggle = 1'($urandom_range(0, 1));
         fill_random(len);
         apply_stimulus(len, 0, -1);
      end

`ifdef SPI_SEQ_RX_SKIP_EN
      $display("[TB] rx skip");
      tx_gaps    = 1'b0;
      rdy_toggle = 1'b0;
      tx_bytes[0:2]  = '{8'h01, 8'h02, 8'h03};
      slv_bytes[0:2] = '{8'hAA, 8'hBB, 8'hCC};
      apply_stimulus(3, 1, -1);
      check_output("t6_rx_literal", 32'(last_rx), 32'h CC);
      apply_bad_cmd(3, 3);
      for (int r = 0; r < 3; r++) begin
         int len;
         int skip;
         len  = $urandom_range(2, MAX_LEN);
         skip = $urandom_range(0, len - 1);
         fill_random(len);
         apply_stimulus(len, skip, -1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
